// File: rtl/mdr_unit.sv
// Memory data register: loads from the C bus or from data memory.
// Optional MDR_SIGN_EXT_EN adds sign-extended byte loads.
module mdr_unit #(
    parameter int DATA_W  = 16,
    parameter int LANES   = DATA_W / 8,
    parameter int SEL_W   = $clog2(LANES),
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cbus_in,
    input  logic              load_c,
    input  logic              rd_req,
    input  logic              byte_mode,
    input  logic [SEL_W-1:0]  byte_sel,
`ifdef MDR_SIGN_EXT_EN
    input  logic              sign_ext,
`endif
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rd_valid,
    output logic [DATA_W-1:0] mdr_out,
    output logic              busy,
    output logic              done,
    output logic              rd_err
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t            state_q, state_n;
    logic [7:0]        cnt_q, cnt_n;
    logic [DATA_W-1:0] mdr_q, mdr_n;
    logic              done_q, done_n;
    logic              err_q, err_n;
    logic              bm_q, bm_n;
    logic [SEL_W-1:0]  sel_q, sel_n;
    logic              sx_q, sx_n;
    logic              sx_in;
    logic [7:0]        lane;
    logic [DATA_W-1:0] cap;

`ifdef MDR_SIGN_EXT_EN
    assign sx_in = sign_ext;
`else
    assign sx_in = 1'b0;
`endif

    // Pick the latched byte lane out of the memory read data.
    always_comb begin
        lane = 8'h00;
        for (int i = 0; i < LANES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                lane = mem_rd_data[8*i +: 8];
            end
        end
    end

    // Format captured read data: full word or extended byte.
    always_comb begin
        if (bm_q) begin
            cap = {{(DATA_W-8){sx_q & lane[7]}}, lane};
        end else begin
            cap = mem_rd_data;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        mdr_n   = mdr_q;
        done_n  = 1'b0;
        err_n   = err_q;
        bm_n    = bm_q;
        sel_n   = sel_q;
        sx_n    = sx_q;
        unique case (state_q)
            S_IDLE: begin
                if (load_c) begin
                    mdr_n = cbus_in;
                end else if (rd_req) begin
                    bm_n    = byte_mode;
                    sel_n   = byte_sel;
                    sx_n    = sx_in;
                    cnt_n   = 8'd0;
                    err_n   = 1'b0;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rd_valid) begin
                    mdr_n   = cap;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (cnt_q == LAST) begin
                    err_n   = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cnt_n = cnt_q + 8'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // State and data registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            mdr_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bm_q    <= 1'b0;
            sel_q   <= '0;
            sx_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            mdr_q   <= mdr_n;
            done_q  <= done_n;
            err_q   <= err_n;
            bm_q    <= bm_n;
            sel_q   <= sel_n;
            sx_q    <= sx_n;
        end
    end

    assign busy      = (state_q == S_WAIT);
    assign mem_rd_en = (state_q == S_WAIT);
    assign mdr_out   = mdr_q;
    assign done      = done_q;
    assign rd_err    = err_q;

endmodule
